dmem_arbiter: RTL and testbench

- Shares the single-port data memory (async word read, write on posedge clk) between the pipeline MEM stage (CPU port) and a DMA/loader port.
- CPU has default priority. A starvation counter forces a DMA slot, and a locked-burst mode gives DMA consecutive beats.
- Sits between the MEM stage / DMA engine and dmem. A granted CPU access has zero added latency; otherwise the CPU is stalled via cpu_stall.

---
 rtl/dmem_arbiter.sv | 111 +++++++++++
 tb/tb_dmem_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter for the single-port data memory.
// The CPU has priority, a starvation counter forces DMA slots, and locked DMA bursts are supported.
module dmem_arbiter #(
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_a,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_a,
  input  logic [31:0] dma_wd,
  input  logic        dma_lock,
  output logic        dma_gnt,
  output logic        dma_ack,
  output logic [31:0] dma_rd,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic {ST_ARB, ST_BURST} state_t;

  localparam logic [3:0] LP_MAX_WAIT  = 4'(MAX_WAIT);
  localparam logic [4:0] LP_MAX_BURST = 5'(MAX_BURST);
  localparam bit         LP_CAN_BURST = (MAX_BURST > 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_wait_cnt, w_wait_nxt;
  logic [3:0]  r_beat_cnt, w_beat_nxt;
  logic        r_dma_ack;
  logic [31:0] r_dma_rd;
  logic        w_force, w_dma_gnt, w_cpu_gnt;
  logic [4:0]  w_beat_sum;

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_beat_nxt  = r_beat_cnt;
    w_force     = dma_req && (r_wait_cnt == LP_MAX_WAIT);
    w_dma_gnt   = 1'b0;
    w_cpu_gnt   = 1'b0;
    w_beat_sum  = 5'd0;
    case (r_state)
      ST_ARB: begin
        w_dma_gnt = dma_req && (!cpu_req || w_force);
        w_cpu_gnt = cpu_req && !w_dma_gnt;
        if (w_dma_gnt || !dma_req)
          w_wait_nxt = 4'd0;
        else if (r_wait_cnt != LP_MAX_WAIT)
          w_wait_nxt = r_wait_cnt + 4'd1;
        if (w_dma_gnt && dma_lock && LP_CAN_BURST) begin
          w_state_nxt = ST_BURST;
          w_beat_nxt  = 4'd1;
        end
      end
      ST_BURST: begin
        w_dma_gnt  = dma_req;
        w_cpu_gnt  = cpu_req && !dma_req;
        w_beat_sum = {1'b0, r_beat_cnt} + 5'(w_dma_gnt);
        // Leaving the burst re-arms the starvation window so the CPU gets its slots back.
        if (!dma_lock || !dma_req || (w_beat_sum == LP_MAX_BURST)) begin
          w_state_nxt = ST_ARB;
          w_wait_nxt  = 4'd0;
          w_beat_nxt  = 4'd0;
        end else begin
          w_beat_nxt = w_beat_sum[3:0];
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
    if (reset) begin
      w_dma_gnt = 1'b0;
      w_cpu_gnt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_ARB;
      r_wait_cnt <= 4'd0;
      r_beat_cnt <= 4'd0;
      r_dma_ack  <= 1'b0;
      r_dma_rd   <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_dma_ack  <= w_dma_gnt;
      if (w_dma_gnt && !dma_we)
        r_dma_rd <= mem_rd;
    end
  end

  assign dma_gnt   = w_dma_gnt;
  assign dma_ack   = r_dma_ack;
  assign dma_rd    = r_dma_rd;
  assign cpu_stall = cpu_req && !w_cpu_gnt && !reset;
  assign cpu_rd    = mem_rd;
  assign mem_a     = w_dma_gnt ? dma_a  : cpu_a;
  assign mem_wd    = w_dma_gnt ? dma_wd : cpu_wd;
  assign mem_we    = w_dma_gnt ? dma_we : (w_cpu_gnt && cpu_we);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter.
// A small behavioural dmem sits behind the arbiter; expected values are hand-derived.
module tb_dmem_arbiter;

  logic        clk, reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_a, cpu_wd, cpu_rd;
  logic        cpu_stall;
  logic        dma_req, dma_we, dma_lock, dma_gnt, dma_ack;
  logic [31:0] dma_a, dma_wd, dma_rd;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  logic [31:0] mem [0:63];
  int n_checks = 0;
  int n_err    = 0;

  dmem_arbiter #(.MAX_WAIT(4), .MAX_BURST(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_a(dma_a), .dma_wd(dma_wd),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rd(dma_rd),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  assign mem_rd = mem[mem_a[7:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = 32'd0; cpu_wd = 32'd0;
    dma_req = 1'b0; dma_we = 1'b0; dma_a = 32'd0; dma_wd = 32'd0; dma_lock = 1'b0;
  endtask

  initial begin
    int beat;
    logic exp_g, prev_g;
    idle_inputs();

    // Reset with both requesters active: nothing may be granted or stalled.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; dma_req = 1'b1; dma_we = 1'b1;
      #1;
      check("rst_dma_gnt", 32'(dma_gnt), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_stall", 32'(cpu_stall), 32'd0);
    end
    @(negedge clk); idle_inputs(); #1;
    check("rst_dma_ack", 32'(dma_ack), 32'd0);
    check("rst_dma_rd", dma_rd, 32'd0);

    // CPU write then read-back of the same word.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 32'h10; cpu_wd = 32'hAA; #1;
    check("cpu_wr_stall", 32'(cpu_stall), 32'd0);
    check("cpu_wr_mem_we", 32'(mem_we), 32'd1);
    check("cpu_wr_mem_a", mem_a, 32'h10);
    @(negedge clk);
    cpu_we = 1'b0; cpu_wd = 32'd0; #1;
    check("cpu_rd_stall", 32'(cpu_stall), 32'd0);
    check("cpu_rd_mem_we", 32'(mem_we), 32'd0);
    check("cpu_rd_data", cpu_rd, 32'hAA);

    // Preload 0x20 = 0x55 through the CPU port.
    @(negedge clk);
    cpu_we = 1'b1; cpu_a = 32'h20; cpu_wd = 32'h55; #1;
    check("preload_mem_we", 32'(mem_we), 32'd1);

    // Starvation: DMA read denied 4 cycles, forced on the 5th.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 32'h0;
      dma_req = 1'b1; dma_we = 1'b0; dma_a = 32'h20; #1;
      check($sformatf("starve_gnt_c%0d", c), 32'(dma_gnt), (c == 4) ? 32'd1 : 32'd0);
      check($sformatf("starve_stall_c%0d", c), 32'(cpu_stall), (c == 4) ? 32'd1 : 32'd0);
    end
    check("starve_mem_a", mem_a, 32'h20);
    @(negedge clk);
    dma_req = 1'b0; #1;
    check("starve_ack", 32'(dma_ack), 32'd1);
    check("starve_rd", dma_rd, 32'h55);
    check("starve_cpu_regrant", 32'(cpu_stall), 32'd0);
    @(negedge clk); #1;
    check("starve_ack_drop", 32'(dma_ack), 32'd0);
    @(negedge clk); idle_inputs(); #1;

    // Locked burst of 10 writes with the CPU always requesting:
    // 4 denied, 8 granted, 4 denied, 2 granted.
    beat = 0; prev_g = 1'b0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 32'h0;
      dma_req = (beat < 10); dma_lock = 1'b1; dma_we = 1'b1;
      dma_a = 32'h40 + 32'(4 * beat); dma_wd = 32'(beat); #1;
      exp_g = (c >= 4 && c <= 11) || (c >= 16);
      check($sformatf("burst_gnt_c%0d", c), 32'(dma_gnt), 32'(exp_g));
      check($sformatf("burst_stall_c%0d", c), 32'(cpu_stall), 32'(exp_g));
      check($sformatf("burst_ack_c%0d", c), 32'(dma_ack), 32'(prev_g));
      prev_g = exp_g;
      if (dma_gnt) beat++;
    end
    check("burst_beats", 32'(beat), 32'd10);
    @(negedge clk);
    dma_req = 1'b0; dma_lock = 1'b0; #1;
    check("burst_last_ack", 32'(dma_ack), 32'd1);
    check("burst_done_stall", 32'(cpu_stall), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 32'h40 + 32'(4 * i); #1;
      check($sformatf("burst_mem_%0d", i), cpu_rd, 32'(i));
    end
    @(negedge clk); idle_inputs(); #1;

    // Early end: lock drops during beat 3, CPU wins the following cycle.
    beat = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 32'h0;
      dma_req = 1'b1; dma_lock = (c < 6); dma_we = 1'b1;
      dma_a = 32'h80 + 32'(4 * beat); dma_wd = 32'h100 + 32'(beat); #1;
      exp_g = (c >= 4 && c <= 6);
      check($sformatf("early_gnt_c%0d", c), 32'(dma_gnt), 32'(exp_g));
      check($sformatf("early_stall_c%0d", c), 32'(cpu_stall), 32'(exp_g));
      if (dma_gnt) beat++;
    end
    @(negedge clk); idle_inputs(); #1;
    @(negedge clk); #1;

    // Reset during beat 5 of a burst.
    beat = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cpu_req = 1'b0; dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b1;
      dma_a = 32'hC0 + 32'(4 * beat); dma_wd = 32'h200 + 32'(beat); #1;
      check($sformatf("rb_gnt_c%0d", c), 32'(dma_gnt), 32'd1);
      if (dma_gnt) beat++;
    end
    @(negedge clk);
    reset = 1'b1; cpu_req = 1'b1; #1;
    check("rb_rst_gnt", 32'(dma_gnt), 32'd0);
    check("rb_rst_mem_we", 32'(mem_we), 32'd0);
    check("rb_rst_stall", 32'(cpu_stall), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      reset = 1'b0; cpu_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b0; #1;
      if (c == 0) check("rb_ack_after", 32'(dma_ack), 32'd0);
      check($sformatf("rb_post_gnt_c%0d", c), 32'(dma_gnt), (c == 4) ? 32'd1 : 32'd0);
      check($sformatf("rb_post_stall_c%0d", c), 32'(cpu_stall), (c == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk); idle_inputs(); #1;
    check("rb_forced_ack", 32'(dma_ack), 32'd1);

    // Idle: nothing moves.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle_inputs(); #1;
      check($sformatf("idle_mem_we_c%0d", c), 32'(mem_we), 32'd0);
      check($sformatf("idle_ack_c%0d", c), 32'(dma_ack), 32'd0);
      check($sformatf("idle_gnt_c%0d", c), 32'(dma_gnt), 32'd0);
      check($sformatf("idle_stall_c%0d", c), 32'(cpu_stall), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
